// File: rtl/apb_pwm_gen_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the APB PWM generator.
package apb_pwm_gen_pkg;

    // Word offsets as decoded from PADDR[4:2]
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_PERIOD     = 3'd1;
    localparam logic [2:0] REG_DUTY       = 3'd2;
    localparam logic [2:0] REG_STATUS     = 3'd3;
    localparam logic [2:0] REG_COUNT      = 3'd4;
    localparam logic [2:0] REG_PERIOD_ACT = 3'd5;
    localparam logic [2:0] REG_DUTY_ACT   = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_POL     = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/apb_pwm_gen_pwm_core.sv
// PWM counter/FSM with double-buffered period and duty; pwm_o and period_done_o lag cnt by 1 cycle.
// No backpressure: shadow values are sampled whenever pending_i is set at IDLE or at a wrap.
module pwm_core #(
    parameter int          CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 2000000,
    parameter int unsigned RST_DUTY   = 150000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             oneshot_i,
    input  logic             pol_i,
    input  logic             pending_i,
    input  logic [CNT_W-1:0] period_sh_i,
    input  logic [CNT_W-1:0] duty_sh_i,
    output logic             running_o,
    output logic             load_ack_o,
    output logic             en_clr_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] period_act_o,
    output logic [CNT_W-1:0] duty_act_o,
    output logic             pwm_o,
    output logic             period_done_o
);
    import apb_pwm_gen_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] duty_q;
    logic             pwm_q;
    logic             pd_q;

    logic wrap;
    logic level_d;

    // A zero period wraps every cycle so the counter can never run away
    assign wrap = (state_q == ST_RUN) &&
                  ((period_q == '0) || (cnt_q == period_q - CNT_ONE));

    assign level_d = (state_q == ST_RUN)
                   ? (((period_q != '0) && (cnt_q < duty_q)) ^ pol_i)
                   : pol_i;

    assign load_ack_o = pending_i && ((state_q == ST_IDLE) || wrap);
    assign en_clr_o   = wrap && oneshot_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= CNT_W'(RST_PERIOD);
            duty_q   <= CNT_W'(RST_DUTY);
            pwm_q    <= 1'b0;
            pd_q     <= 1'b0;
        end else begin
            pwm_q <= level_d;
            pd_q  <= wrap;
            if (load_ack_o) begin
                period_q <= period_sh_i;
                duty_q   <= duty_sh_i;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en_i && (period_q != '0)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (oneshot_i || !en_i) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign running_o     = (state_q == ST_RUN);
    assign cnt_o         = cnt_q;
    assign period_act_o  = period_q;
    assign duty_act_o    = duty_q;
    assign pwm_o         = pwm_q;
    assign period_done_o = pd_q;

endmodule

// File: rtl/apb_pwm_gen.sv
// APB3 PWM generator: register decode, CTRL and shadow registers around pwm_core.
// Zero-wait-state APB (PREADY tied 1); pwm_out/period_done registered, 1 cycle after the counter.
module apb_pwm_gen #(
    parameter int          CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 2000000,
    parameter int unsigned RST_DUTY   = 150000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        pwm_out,
    output logic        period_done
);
    import apb_pwm_gen_pkg::*;

    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             pending_q, pending_d;

    logic             wr_en;
    logic [2:0]       reg_sel;
    logic             running;
    logic             load_ack;
    logic             en_clr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act;
    logic             unused_paddr;

    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign reg_sel      = PADDR[4:2];
    assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};
    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;

    // A shadow write on the same cycle as a load wins, so the new value waits for the next boundary
    always_comb begin
        ctrl_d      = ctrl_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        pending_d   = pending_q;
        if (load_ack) begin
            pending_d = 1'b0;
        end
        if (en_clr) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_en) begin
            case (reg_sel)
                REG_CTRL:   ctrl_d = PWDATA[2:0];
                REG_PERIOD: begin
                    period_sh_d = PWDATA[CNT_W-1:0];
                    pending_d   = 1'b1;
                end
                REG_DUTY: begin
                    duty_sh_d = PWDATA[CNT_W-1:0];
                    pending_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            ctrl_q      <= '0;
            period_sh_q <= CNT_W'(RST_PERIOD);
            duty_sh_q   <= CNT_W'(RST_DUTY);
            pending_q   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (reg_sel)
                REG_CTRL:       PRDATA = {29'd0, ctrl_q};
                REG_PERIOD:     PRDATA = 32'(period_sh_q);
                REG_DUTY:       PRDATA = 32'(duty_sh_q);
                REG_STATUS:     PRDATA = {30'd0, pending_q, running};
                REG_COUNT:      PRDATA = 32'(cnt);
                REG_PERIOD_ACT: PRDATA = 32'(period_act);
                REG_DUTY_ACT:   PRDATA = 32'(duty_act);
                default:        PRDATA = '0;
            endcase
        end
    end

    pwm_core #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD),
        .RST_DUTY   (RST_DUTY)
    ) u_core (
        .clk_i         (PCLK),
        .rst_ni        (PRESERN),
        .en_i          (ctrl_q[CTRL_EN]),
        .oneshot_i     (ctrl_q[CTRL_ONESHOT]),
        .pol_i         (ctrl_q[CTRL_POL]),
        .pending_i     (pending_q),
        .period_sh_i   (period_sh_q),
        .duty_sh_i     (duty_sh_q),
        .running_o     (running),
        .load_ack_o    (load_ack),
        .en_clr_o      (en_clr),
        .cnt_o         (cnt),
        .period_act_o  (period_act),
        .duty_act_o    (duty_act),
        .pwm_o         (pwm_out),
        .period_done_o (period_done)
    );

endmodule
